ex_div: RTL
===========

Name: ex_div

Overview:
- Iterative 32-bit divider owned by the EX stage. It is started by DIV/DIVU after the ID/EX register delivers the operands.
- Computes one quotient bit per cycle; the EX stage holds the pipeline stall request high until ready_o rises.
- Result is packed {remainder, quotient} for the HI/LO write path.
- Supports signed and unsigned division, a divide-by-zero shortcut, and annulment when the pipeline is flushed.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge
- rst  input  1  reset; asynchronous, active-low
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start acceptance
- opdata1_i  input  DATA_W  dividend; sampled at start acceptance
- opdata2_i  input  DATA_W  divisor; sampled at start acceptance
- start_i  input  1  level request from EX; held high until ready_o is seen
- annul_i  input  1  abort request (flush or exception)
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}
- ready_o  output  1  result valid

Behaviour:
- Reset (rst low, any time, including mid-division):
  - Immediately clears state to IDLE, counter to 0, result_o to 0, ready_o to 0.
  - No partial result survives reset.
- States: IDLE, BY_ZERO, ON, END. Encode in 2 bits.
- IDLE:
  - If start_i=1 and annul_i=0 and opdata2_i=0: go to BY_ZERO.
  - If start_i=1 and annul_i=0 and opdata2_i!=0: go to ON, counter=0, latch signed_div_i and the operand signs.
  - Operand load: in signed mode each operand is replaced by its two's-complement magnitude if negative; in unsigned mode operands are used raw.
  - Working register (65 bits) = {32'b0, |dividend|, 1'b0}.
  - Otherwise stay in IDLE. ready_o=0 and result_o=0 throughout IDLE.
- BY_ZERO: next edge unconditionally loads a zero result and goes to END. The final result is 0 for both halves.
- ON:
  - If annul_i=1, go to IDLE at the next edge, counter to 0, ready_o stays 0. Annul takes priority over iteration.
  - Else, while counter < DATA_W: restoring step.
    - Compute trial = working[64:32] - {1'b0, |divisor|}.
    - If trial is negative: shift working left 1 with a 0 inserted.
    - Else: working = {trial[31:0], working[31:0], 1'b1}.
    - counter increments.
  - When counter == DATA_W: apply sign correction and go to END.
    - In signed mode, the quotient is negated if the operand signs differ.
    - In signed mode, the remainder is negated if the dividend was negative.
    - Remainder = working[64:33]; quotient = working[31:0].
- END:
  - ready_o=1 and result_o holds the final value while start_i=1.
  - When start_i=0: go to IDLE, ready_o=0, result_o cleared to 0.
  - annul_i is ignored in END.
- Latency:
  - Start acceptance edge is E0.
  - Non-zero divisor: 32 iteration edges, then 1 finalize edge; ready_o is high after edge E0+33.
  - Divisor zero: ready_o is high after edge E0+1.
- start_i while not in IDLE is ignored; operand changes after acceptance have no effect.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) wraps to quotient 0x80000000, remainder 0. No trap is raised here.
- Signed mode, dividend 0x80000000: its magnitude 0x80000000 is treated as unsigned, so the result is exact.
- Back-to-back operations: after END→IDLE, a new start is accepted on the very next edge if start_i is high again.

Test Plan:
- Unsigned 7/2: start_i=1, signed=0 → ready_o rises after 34 edges; result_o=0x00000001_00000003; drop start_i → ready_o=0 and result_o=0 next edge.
- Signed -7/2: opdata1=0xFFFFFFF9, opdata2=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also check 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero: opdata2=0, any opdata1 → ready_o high after 2 edges; result_o=0.
- Annul mid-op: start 100/3, assert annul_i for one cycle at iteration 10 → state IDLE, ready_o never rises. A following start of 100/3 yields quotient 0x21, remainder 1 with full latency.
- Boundaries:
  - Signed 0x80000000/0xFFFFFFFF → result_o=0x00000000_80000000.
  - Unsigned 0xFFFFFFFF/1 → 0x00000000_FFFFFFFF.
  - Unsigned 5/9 → quotient 0, remainder 5.
- Async reset at iteration 20 (rst low between edges) → outputs zero immediately without a clock edge. After release, a new start completes normally; operand changes during ON do not alter the result.

Source files
------------

// File: rtl/ex_div.sv
// Iterative restoring divider for the EX stage: one quotient bit per cycle,
// result packed {remainder, quotient} for the HI/LO write path.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BY_ZERO = 2'b01,
    ON      = 2'b10,
    END     = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*DATA_W:0]  work;
  logic [DATA_W-1:0]  divisor_mag;
  logic               signed_q;
  logic               dividend_neg_q;
  logic               divisor_neg_q;

  logic               accept;
  logic               dividend_neg;
  logic               divisor_neg;
  logic [DATA_W-1:0]  dividend_mag;
  logic [DATA_W:0]    trial;
  logic [DATA_W-1:0]  quot_raw;
  logic [DATA_W-1:0]  rem_raw;
  logic [DATA_W-1:0]  quot_fix;
  logic [DATA_W-1:0]  rem_fix;

  assign accept = start_i && !annul_i;

  // Operand magnitudes are only taken for negative operands in signed mode.
  always_comb begin
    dividend_neg = signed_div_i & opdata1_i[DATA_W-1];
    divisor_neg  = signed_div_i & opdata2_i[DATA_W-1];
    dividend_mag = dividend_neg ? -opdata1_i : opdata1_i;
  end

  always_comb begin
    trial    = work[2*DATA_W:DATA_W] - {1'b0, divisor_mag};
    quot_raw = work[DATA_W-1:0];
    rem_raw  = work[2*DATA_W:DATA_W+1];
    quot_fix = (signed_q && (dividend_neg_q ^ divisor_neg_q)) ? -quot_raw : quot_raw;
    rem_fix  = (signed_q && dividend_neg_q) ? -rem_raw : rem_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (opdata2_i == '0) ? BY_ZERO : ON;
        end
      end
      BY_ZERO: state_nxt = END;
      ON: begin
        if (annul_i) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = END;
        end
      end
      END: begin
        if (!start_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring iterations, sign fix-up and result hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      work           <= '0;
      divisor_mag    <= '0;
      signed_q       <= 1'b0;
      dividend_neg_q <= 1'b0;
      divisor_neg_q  <= 1'b0;
      result_o       <= '0;
      ready_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (accept && (opdata2_i != '0)) begin
            cnt            <= '0;
            signed_q       <= signed_div_i;
            dividend_neg_q <= dividend_neg;
            divisor_neg_q  <= divisor_neg;
            divisor_mag    <= divisor_neg ? -opdata2_i : opdata2_i;
            work           <= {{DATA_W{1'b0}}, dividend_mag, 1'b0};
          end
        end
        BY_ZERO: begin
          result_o <= '0;
          ready_o  <= 1'b1;
        end
        ON: begin
          if (annul_i) begin
            cnt     <= '0;
            ready_o <= 1'b0;
          end else if (cnt != CNT_LAST) begin
            // A negative trial means the divisor did not fit: restore by plain shift.
            if (trial[DATA_W]) begin
              work <= {work[2*DATA_W-1:0], 1'b0};
            end else begin
              work <= {trial[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            result_o <= {rem_fix, quot_fix};
            ready_o  <= 1'b1;
            cnt      <= '0;
          end
        end
        END: begin
          if (!start_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end
        default: begin
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
